dot_accum: RTL and testbench



---
 rtl/dot_accum_if.sv | 26 ++
 rtl/dot_accum.sv | 186 ++++++++++++++++++
 tb/tb_dot_accum.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_accum_if.sv
// dot_accum_if: beat-issue side (from the MAC cluster controller) and
// result side (to the softmax/score stage) of the dot-product accumulator.
interface dot_accum_if #(
   parameter int PROD_WIDTH = 16,
   parameter int ACC_WIDTH  = 32
);
   logic                  in_valid;
   logic                  in_last;
   logic                  in_ready;
   logic [PROD_WIDTH-1:0] psum;
   logic                  dot_valid;
   logic                  dot_ready;
   logic [ACC_WIDTH-1:0]  dot_out;
   logic                  busy;
   logic                  err_len;

   modport master (
      output in_valid, in_last, psum, dot_ready,
      input  in_ready, dot_valid, dot_out, busy, err_len
   );

   modport slave (
      input  in_valid, in_last, psum, dot_ready,
      output in_ready, dot_valid, dot_out, busy, err_len
   );
endinterface

// File: rtl/dot_accum.sv
// dot_accum: sums the MAC cluster's per-beat partial sums into full dot
// products. A {valid,last} delay line follows each beat through the cluster
// so its flags line up with its psum; finished results wait in a 2-entry
// FIFO until the score stage takes them.
module dot_accum #(
   parameter int PROD_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int LAT        = 4,
   parameter int MAX_CHUNKS = 64,
   parameter bit SIGNED     = 1'b1
) (
   input logic        clk,
   input logic        rst,
   dot_accum_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_CHUNKS + 1);
   localparam int LIF_W = $clog2(LAT + 3);

   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   // Widen a partial sum to accumulator width.
   function automatic logic signed [ACC_WIDTH-1:0] extend(input logic [PROD_WIDTH-1:0] p);
      if (SIGNED) return ACC_WIDTH'($signed(p));
      return ACC_WIDTH'(p);
   endfunction

   // Accumulator add; overflow wraps, no saturation.
   function automatic logic signed [ACC_WIDTH-1:0] wrap_add(input logic signed [ACC_WIDTH-1:0] a,
                                                             input logic signed [ACC_WIDTH-1:0] b);
      return a + b;
   endfunction

   logic                        in_ready;
   logic                        beat_ok;
   logic                        beat_last;
   logic [LAT-1:0]              vld_p;
   logic [LAT-1:0]              last_p;
   logic                        d_valid;
   logic                        d_last;
   logic [LIF_W-1:0]            lasts_in_flight;

   state_t                      state_q;
   state_t                      state_d;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] acc_d;
   logic signed [ACC_WIDTH-1:0] ext;
   logic signed [ACC_WIDTH-1:0] sum;
   logic signed [ACC_WIDTH-1:0] push_data;
   logic [CNT_W-1:0]            cnt_q;
   logic [CNT_W-1:0]            cnt_d;
   logic [CNT_W-1:0]            cnt_inc;
   logic                        err_q;
   logic                        err_set;
   logic                        push;
   logic                        push_ok;
   logic                        pop;

   logic [ACC_WIDTH-1:0]        mem [2];
   logic                        wr_ptr;
   logic                        rd_ptr;
   logic [1:0]                  fifo_cnt;
   logic                        dot_valid;

   // A last offered while in_ready is low is dropped whole, so it can never
   // reach a full FIFO; non-last beats are always taken.
   assign beat_ok   = bus.in_valid & ~(bus.in_last & ~in_ready);
   assign beat_last = bus.in_valid & bus.in_last & in_ready;

   // Delay line: stage LAT-1 carries the flags of the psum on the bus now.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p  <= '0;
         last_p <= '0;
      end else begin
         vld_p[0]  <= beat_ok;
         last_p[0] <= beat_last;
         for (int i = 1; i < LAT; i++) begin
            vld_p[i]  <= vld_p[i-1];
            last_p[i] <= last_p[i-1];
         end
      end
   end

   assign d_valid = vld_p[LAT-1];
   assign d_last  = last_p[LAT-1];

   // Count finished vectors still inside the cluster; each will need a FIFO slot.
   always_comb begin
      lasts_in_flight = '0;
      for (int i = 0; i < LAT; i++) lasts_in_flight = lasts_in_flight + LIF_W'(last_p[i]);
   end

   assign in_ready = (LIF_W'(fifo_cnt) + lasts_in_flight) < LIF_W'(2);

   assign ext     = extend(bus.psum);
   assign sum     = wrap_add(acc_q, ext);
   assign cnt_inc = (cnt_q == CNT_W'(MAX_CHUNKS)) ? cnt_q : cnt_q + CNT_W'(1);

   // Accumulator FSM next-state: start, extend or close a vector on each aligned beat.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      push_data = ext;
      err_set   = 1'b0;
      case (state_q)
         IDLE: begin
            if (d_valid) begin
               if (d_last) begin
                  push      = 1'b1;
                  push_data = ext;
               end else begin
                  acc_d   = ext;
                  cnt_d   = CNT_W'(1);
                  state_d = ACCUM;
                  err_set = (MAX_CHUNKS <= 1);
               end
            end
         end
         ACCUM: begin
            if (d_valid) begin
               if (d_last) begin
                  push      = 1'b1;
                  push_data = sum;
                  acc_d     = '0;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end else begin
                  acc_d   = sum;
                  cnt_d   = cnt_inc;
                  err_set = (cnt_inc == CNT_W'(MAX_CHUNKS));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Accumulator FSM state, running sum, beat count and sticky length error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         if (err_set) err_q <= 1'b1;
      end
   end

   assign dot_valid = (fifo_cnt != 2'd0);
   assign pop       = dot_valid & bus.dot_ready;
   assign push_ok   = push & ((fifo_cnt != 2'd2) | pop);

   // Result FIFO: two entries, ordered, push and pop in the same cycle allowed.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push_ok, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.dot_valid = dot_valid;
   assign bus.dot_out   = mem[rd_ptr];
   assign bus.busy      = (state_q == ACCUM) | (|vld_p);
   assign bus.err_len   = err_q;
endmodule

// File: tb/tb_dot_accum.sv
// tb_dot_accum: three dot_accum instances (signed/32-bit, unsigned/16-bit
// with short length limit, unsigned/32-bit) share one beat stream. A cluster
// model delays psum by LAT; a transaction-level model predicts results,
// flow control, busy and err_len.
module tb_dot_accum;
   localparam int LAT   = 4;
   localparam int NEVER = 32'h7fff_ffff;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic        dot_ready;
   logic [15:0] psum;

   always #5 clk = ~clk;

   dot_accum_if #(.PROD_WIDTH(16), .ACC_WIDTH(32)) bus_a ();
   dot_accum_if #(.PROD_WIDTH(16), .ACC_WIDTH(16)) bus_b ();
   dot_accum_if #(.PROD_WIDTH(16), .ACC_WIDTH(32)) bus_c ();

   assign bus_a.in_valid = in_valid;  assign bus_a.in_last = in_last;
   assign bus_a.psum = psum;          assign bus_a.dot_ready = dot_ready;
   assign bus_b.in_valid = in_valid;  assign bus_b.in_last = in_last;
   assign bus_b.psum = psum;          assign bus_b.dot_ready = dot_ready;
   assign bus_c.in_valid = in_valid;  assign bus_c.in_last = in_last;
   assign bus_c.psum = psum;          assign bus_c.dot_ready = dot_ready;

   dot_accum #(.PROD_WIDTH(16), .ACC_WIDTH(32), .LAT(LAT), .MAX_CHUNKS(64), .SIGNED(1'b1))
      u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   dot_accum #(.PROD_WIDTH(16), .ACC_WIDTH(16), .LAT(LAT), .MAX_CHUNKS(4), .SIGNED(1'b0))
      u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
   dot_accum #(.PROD_WIDTH(16), .ACC_WIDTH(32), .LAT(LAT), .MAX_CHUNKS(64), .SIGNED(1'b0))
      u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      int          at;
   } res_t;

   res_t        exp_q[$];
   res_t        obs_q[$];
   logic [15:0] clus[$];
   longint      sum_s, sum_u;
   int          k, last_issue, cyc, last_sent_cyc;
   bit          open_vec, rdy_mode;
   int          err_at [3];
   int          maxc   [3] = '{64, 4, 64};
   string       nm     [3] = '{"a", "b", "c"};
   int          n_vec, n_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] pick(input res_t r, input int i);
      return (i == 0) ? r.a : (i == 1) ? r.b : r.c;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      sum_s = 0; sum_u = 0; k = 0;
      open_vec = 1'b0;
      last_issue = -1000;
      for (int i = 0; i < 3; i++) err_at[i] = NEVER;
   endtask

   // One clock cycle: check outputs at the negedge, drive inputs, advance the model.
   task automatic tick(input bit v, input bit l, input logic [15:0] x, input bit rdy, input bit r);
      logic [31:0] gv [3], go [3], gr [3], gb [3], ge [3];
      bit   ev, ir, acc;
      res_t nr;
      gv[0] = 32'(bus_a.dot_valid); gv[1] = 32'(bus_b.dot_valid); gv[2] = 32'(bus_c.dot_valid);
      go[0] = bus_a.dot_out;        go[1] = 32'(bus_b.dot_out);   go[2] = bus_c.dot_out;
      gr[0] = 32'(bus_a.in_ready);  gr[1] = 32'(bus_b.in_ready);  gr[2] = 32'(bus_c.in_ready);
      gb[0] = 32'(bus_a.busy);      gb[1] = 32'(bus_b.busy);      gb[2] = 32'(bus_c.busy);
      ge[0] = 32'(bus_a.err_len);   ge[1] = 32'(bus_b.err_len);   ge[2] = 32'(bus_c.err_len);
      ev = (exp_q.size() != 0) && (exp_q[0].at <= cyc);
      ir = (exp_q.size() < 2);
      for (int i = 0; i < 3; i++) begin
         chk({nm[i], ".dot_valid"}, gv[i], 32'(ev));
         if (ev) chk({nm[i], ".dot_out"}, go[i], pick(exp_q[0], i));
         chk({nm[i], ".in_ready"}, gr[i], 32'(ir));
         chk({nm[i], ".busy"}, gb[i], 32'(open_vec || (cyc - last_issue <= LAT)));
         chk({nm[i], ".err_len"}, ge[i], 32'(cyc >= err_at[i]));
      end
      rst = r; in_valid = v; in_last = l; dot_ready = rdy;
      psum = clus.pop_front();
      clus.push_back(v ? x : 16'($urandom));
      if (bus_a.dot_valid && rdy) begin
         nr.a = go[0]; nr.b = go[1]; nr.c = go[2]; nr.at = cyc;
         obs_q.push_back(nr);
      end
      if (ev && rdy) void'(exp_q.pop_front());
      acc = v && !(l && !ir) && !r;
      if (acc) begin
         last_issue = cyc;
         k++;
         sum_s += longint'($signed(x));
         sum_u += longint'(x);
         for (int i = 0; i < 3; i++)
            if (!l && k >= maxc[i] && err_at[i] == NEVER) err_at[i] = cyc + LAT + 1;
         if (l) begin
            nr.a = 32'(sum_s); nr.b = {16'h0, 16'(sum_u)}; nr.c = 32'(sum_u); nr.at = cyc + LAT + 1;
            exp_q.push_back(nr);
            sum_s = 0; sum_u = 0; k = 0;
            open_vec = 1'b0;
         end else begin
            open_vec = 1'b1;
         end
      end
      @(posedge clk);
      cyc++;
      if (r) model_reset();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0, rdy_mode, 1'b0);
   endtask

   // Issue one beat; a last waits (bounded) until in_ready.
   task automatic send(input logic [15:0] x, input bit l);
      int guard = 0;
      while (l && !bus_a.in_ready && guard < 50) begin
         tick(1'b0, 1'b0, 16'h0, rdy_mode, 1'b0);
         guard++;
      end
      if (l) chk("send.in_ready", 32'(bus_a.in_ready), 32'd1);
      last_sent_cyc = cyc;
      tick(1'b1, l, x, rdy_mode, 1'b0);
   endtask

   initial begin
      int          rem;
      bit          rdy;
      logic [15:0] x;
      n_vec = 0; n_err = 0; cyc = 0;
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; dot_ready = 1'b0; psum = '0;
      rdy_mode = 1'b1;
      for (int i = 0; i < LAT; i++) clus.push_back(16'h0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.a.dot_out", bus_a.dot_out, 32'h0);
      chk("rst.b.dot_out", 32'(bus_b.dot_out), 32'h0);
      chk("rst.c.dot_out", bus_c.dot_out, 32'h0);

      // Four-beat vector 3+5+7+1.
      idle(2);
      obs_q.delete();
      send(16'd3, 1'b0); send(16'd5, 1'b0); send(16'd7, 1'b0); send(16'd1, 1'b1);
      idle(8);
      chk("t1.count", 32'(obs_q.size()), 32'd1);
      chk("t1.value", obs_q[0].a, 32'd16);
      chk("t1.latency", 32'(obs_q[0].at - last_sent_cyc), 32'(LAT + 1));
      chk("t1.busy", 32'(bus_a.busy), 32'd0);

      // Single-beat vector: sign vs zero extension.
      obs_q.delete();
      send(16'hFFFF, 1'b1);
      idle(7);
      chk("single.a", obs_q[0].a, 32'hFFFF_FFFF);
      chk("single.b", obs_q[0].b, 32'h0000_FFFF);
      chk("single.c", obs_q[0].c, 32'h0000_FFFF);

      // Modulo wrap in the 16-bit accumulator.
      obs_q.delete();
      send(16'hFFFF, 1'b0); send(16'h0002, 1'b1);
      idle(8);
      chk("wrap.a", obs_q[0].a, 32'h0000_0001);
      chk("wrap.b", obs_q[0].b, 32'h0000_0001);
      chk("wrap.c", obs_q[0].c, 32'h0001_0001);

      // Back-pressure: two results fill the budget, third waits.
      obs_q.delete();
      rdy_mode = 1'b0;
      send(16'd10, 1'b1); send(16'd20, 1'b1);
      chk("bp.in_ready_low", 32'(bus_a.in_ready), 32'd0);
      idle(8);
      chk("bp.held", 32'(bus_a.in_ready), 32'd0);
      tick(1'b1, 1'b1, 16'd99, 1'b0, 1'b0);
      rdy_mode = 1'b1;
      send(16'd30, 1'b1);
      idle(10);
      chk("bp.count", 32'(obs_q.size()), 32'd3);
      chk("bp.first", obs_q[0].a, 32'd10);
      chk("bp.second", obs_q[1].a, 32'd20);
      chk("bp.third", obs_q[2].a, 32'd30);

      // Length error on the MAX_CHUNKS=4 instance.
      obs_q.delete();
      for (int i = 0; i < 4; i++) send(16'd1, 1'b0);
      send(16'd1, 1'b1);
      idle(8);
      chk("len.a", obs_q[0].a, 32'd5);
      chk("len.b", obs_q[0].b, 32'd5);
      chk("len.err_b", 32'(bus_b.err_len), 32'd1);
      chk("len.err_a", 32'(bus_a.err_len), 32'd0);
      idle(6);
      chk("len.err_b_sticky", 32'(bus_b.err_len), 32'd1);

      // Reset mid-vector: partial result is lost.
      obs_q.delete();
      for (int i = 0; i < 4; i++) send(16'(i + 2), 1'b0);
      idle(2);
      tick(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      idle(10);
      chk("rstmid.none", 32'(obs_q.size()), 32'd0);
      chk("rstmid.err_b", 32'(bus_b.err_len), 32'd0);
      send(16'd4, 1'b0); send(16'd6, 1'b1);
      idle(8);
      chk("rstmid.count", 32'(obs_q.size()), 32'd1);
      chk("rstmid.value", obs_q[0].a, 32'd10);

      // Randomized traffic with random back-pressure.
      rem = 0;
      for (int n = 0; n < 3000; n++) begin
         rdy = ($urandom_range(0, 9) < 7);
         x   = 16'($urandom);
         if (n == 1500) begin
            tick(1'b0, 1'b0, x, rdy, 1'b1);
            rem = 0;
         end else begin
            if (rem == 0) rem = $urandom_range(1, 6);
            if ($urandom_range(0, 9) < 6 && (rem > 1 || bus_a.in_ready)) begin
               tick(1'b1, rem == 1, x, rdy, 1'b0);
               rem--;
            end else begin
               tick(1'b0, 1'b0, x, rdy, 1'b0);
            end
         end
      end
      rdy_mode = 1'b1;
      idle(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d of %0d checks miscompared", n_err, n_vec);
      $fatal(1, "watchdog");
   end
endmodule
